legv8_control_unit: RTL and testbench

LEGV8_CONTROL_UNIT -- requirements
Module: legv8_control_unit

---
 rtl/legv8_control_unit.sv | 215 +++++++++++++++++++++
 tb/tb_legv8_control_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control unit: decodes one instruction at a time into a
// sequence of registered datapath control words and tracks the program counter.
module legv8_control_unit #(
  parameter logic [4:0]  SCRATCH_REG = 5'd7,
  parameter logic [63:0] PC_RESET    = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  status,
  output logic [31:0] ControlWord,
  output logic [63:0] constant,
  output logic [63:0] pc,
  output logic        retire,
  output logic        illegal
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [4:0] MX_STORE = 5'b00111;
  localparam logic [4:0] MX_LOAD  = 5'b01000;
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {IDLE, EXEC, MEM_ADDR, MEM_DATA} state_t;
  typedef enum logic [2:0] {CL_ALU, CL_LDUR, CL_STUR, CL_CBZ, CL_B, CL_ILLEGAL} op_class_t;

  state_t      state_reg, state_next;
  op_class_t   class_reg, class_next;
  logic [31:0] cw_reg, cw_next;
  logic [63:0] const_reg, const_next;
  logic [63:0] pc_reg, pc_next;
  logic [63:0] offset_reg, offset_next;
  logic [4:0]  rt_reg, rt_next;

  op_class_t   dec_class;
  logic [31:0] dec_cw;
  logic [63:0] dec_const;
  logic        dec_const_en;
  logic [63:0] dec_offset;
  logic        take_branch;

  logic [4:0]  rd, rn, rm;
  logic        unused_status;

  assign rd = instruction[4:0];
  assign rn = instruction[9:5];
  assign rm = instruction[20:16];
  // Only the Z flag steers control flow; the other flags are datapath-only.
  assign unused_status = ^status[3:1];

  function automatic logic [31:0] make_cw(
    input logic [4:0] mx,
    input logic       en_mem,
    input logic       mw,
    input logic       en_alu,
    input logic       md,
    input logic       c0,
    input logic [4:0] fs,
    input logic       mb,
    input logic       rw,
    input logic [4:0] sb,
    input logic [4:0] sa,
    input logic [4:0] da
  );
    return {mx, en_mem, mw, en_alu, md, c0, fs, mb, rw, sb, sa, da};
  endfunction

  // Instruction decode: the first control word plus what later states need.
  always_comb begin
    dec_class    = CL_ILLEGAL;
    dec_cw       = '0;
    dec_const    = const_reg;
    dec_const_en = 1'b0;
    dec_offset   = '0;
    if (instruction[31:21] == OP_ADD) begin
      dec_class = CL_ALU;
      dec_cw    = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FS_ADD, 1'b0, 1'b1, rm, rn, rd);
    end else if (instruction[31:21] == OP_SUB) begin
      dec_class = CL_ALU;
      dec_cw    = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FS_SUB, 1'b0, 1'b1, rm, rn, rd);
    end else if (instruction[31:21] == OP_AND) begin
      dec_class = CL_ALU;
      dec_cw    = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FS_AND, 1'b0, 1'b1, rm, rn, rd);
    end else if (instruction[31:21] == OP_ORR) begin
      dec_class = CL_ALU;
      dec_cw    = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FS_ORR, 1'b0, 1'b1, rm, rn, rd);
    end else if (instruction[31:21] == OP_LDUR || instruction[31:21] == OP_STUR) begin
      // Address phase: scratch <= Rn + sext(imm9).
      dec_class    = (instruction[31:21] == OP_LDUR) ? CL_LDUR : CL_STUR;
      dec_cw       = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b1,
                             ZERO_REG, rn, SCRATCH_REG);
      dec_const    = {{55{instruction[20]}}, instruction[20:12]};
      dec_const_en = 1'b1;
    end else if (instruction[31:22] == OP_ADDI || instruction[31:22] == OP_SUBI ||
                 instruction[31:22] == OP_ANDI || instruction[31:22] == OP_ORRI) begin
      dec_class    = CL_ALU;
      dec_const    = {52'd0, instruction[21:10]};
      dec_const_en = 1'b1;
      case (instruction[31:22])
        OP_ADDI: dec_cw = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b1, rm, rn, rd);
        OP_SUBI: dec_cw = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FS_SUB, 1'b1, 1'b1, rm, rn, rd);
        OP_ANDI: dec_cw = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FS_AND, 1'b1, 1'b1, rm, rn, rd);
        default: dec_cw = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FS_ORR, 1'b1, 1'b1, rm, rn, rd);
      endcase
    end else if (instruction[31:24] == OP_CBZ) begin
      // Rt OR X31 drives the Z flag that decides the branch at the end of EXEC.
      dec_class  = CL_CBZ;
      dec_cw     = make_cw(5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FS_ORR, 1'b0, 1'b0,
                           ZERO_REG, rd, 5'd0);
      dec_offset = {{43{instruction[23]}}, instruction[23:5], 2'b00};
    end else if (instruction[31:26] == OP_B) begin
      dec_class  = CL_B;
      dec_offset = {{36{instruction[25]}}, instruction[25:0], 2'b00};
    end
  end

  assign take_branch = (class_reg == CL_B) || (class_reg == CL_CBZ && status[0]);

  always_comb begin
    state_next  = state_reg;
    class_next  = class_reg;
    cw_next     = cw_reg;
    const_next  = const_reg;
    pc_next     = pc_reg;
    offset_next = offset_reg;
    rt_next     = rt_reg;
    instr_ready = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_ready = 1'b1;
        cw_next     = '0;
        if (instr_valid) begin
          cw_next     = dec_cw;
          class_next  = dec_class;
          offset_next = dec_offset;
          rt_next     = rd;
          if (dec_const_en) const_next = dec_const;
          state_next  = (dec_class == CL_LDUR || dec_class == CL_STUR) ? MEM_ADDR : EXEC;
        end
      end
      EXEC: begin
        retire     = 1'b1;
        illegal    = (class_reg == CL_ILLEGAL);
        pc_next    = pc_reg + (take_branch ? offset_reg : 64'd4);
        cw_next    = '0;
        state_next = IDLE;
      end
      MEM_ADDR: begin
        // Data phase uses the scratch register written during the address phase.
        if (class_reg == CL_LDUR)
          cw_next = make_cw(MX_LOAD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FS_ORR, 1'b0, 1'b1,
                            ZERO_REG, SCRATCH_REG, rt_reg);
        else
          cw_next = make_cw(MX_STORE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, FS_ORR, 1'b0, 1'b0,
                            SCRATCH_REG, rt_reg, 5'd0);
        state_next = MEM_DATA;
      end
      MEM_DATA: begin
        retire     = 1'b1;
        pc_next    = pc_reg + 64'd4;
        cw_next    = '0;
        state_next = IDLE;
      end
      default: begin
        cw_next    = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      class_reg  <= CL_ALU;
      cw_reg     <= '0;
      const_reg  <= '0;
      pc_reg     <= PC_RESET;
      offset_reg <= '0;
      rt_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      class_reg  <= class_next;
      cw_reg     <= cw_next;
      const_reg  <= const_next;
      pc_reg     <= pc_next;
      offset_reg <= offset_next;
      rt_reg     <= rt_next;
    end
  end

  assign ControlWord = cw_reg;
  assign constant    = const_reg;
  assign pc          = pc_reg;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Self-checking bench for legv8_control_unit: directed vectors followed by random
// instructions compared against an instruction-level reference model.
module tb_legv8_control_unit;

  localparam logic [63:0] PC_RESET_TB = 64'd0;
  localparam int          SCRATCH     = 7;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  status;
  logic [31:0] ControlWord;
  logic [63:0] constant;
  logic [63:0] pc;
  logic        retire;
  logic        illegal;

  int tests;
  int fails;
  logic [63:0] exp_pc;
  logic [63:0] exp_const;

  typedef enum {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_ANDI, K_ORRI,
                K_LDUR, K_STUR, K_CBZ, K_B, K_ILL} kind_t;

  legv8_control_unit #(.SCRATCH_REG(5'd7), .PC_RESET(PC_RESET_TB)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .status(status), .ControlWord(ControlWord),
    .constant(constant), .pc(pc), .retire(retire), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic kind_t classify(input logic [31:0] ins);
    case (ins[31:21])
      11'b10001011000: return K_ADD;
      11'b11001011000: return K_SUB;
      11'b10001010000: return K_AND;
      11'b10101010000: return K_ORR;
      11'b11111000010: return K_LDUR;
      11'b11111000000: return K_STUR;
      default: ;
    endcase
    case (ins[31:22])
      10'b1001000100: return K_ADDI;
      10'b1101000100: return K_SUBI;
      10'b1001001000: return K_ANDI;
      10'b1011001000: return K_ORRI;
      default: ;
    endcase
    if (ins[31:24] == 8'b10110100) return K_CBZ;
    if (ins[31:26] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  // Field weights of the control word, most significant field first.
  function automatic logic [31:0] pack(input longint mx, en_mem, mw, en_alu, md, c0, fs,
                                       mb, rw, sb, sa, da);
    longint v;
    v = mx * 2**27 + en_mem * 2**26 + mw * 2**25 + en_alu * 2**24 + md * 2**23 + c0 * 2**22
      + fs * 2**17 + mb * 2**16 + rw * 2**15 + sb * 2**10 + sa * 2**5 + da;
    return 32'(v);
  endfunction

  function automatic longint sext(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  // Expected control words / flags for one instruction; advances exp_pc and exp_const.
  task automatic model(input logic [31:0] ins, input logic z, output logic [31:0] w1,
                       output logic [31:0] w2, output bit mem, output bit ill);
    kind_t  k;
    longint fs, c0, rd, rn, rm;
    bit     alu, imm;
    k  = classify(ins);
    rd = ins[4:0]; rn = ins[9:5]; rm = ins[20:16];
    w1 = 0; w2 = 0; mem = 0; ill = 0; alu = 1; imm = 0; fs = 0; c0 = 0;
    case (k)
      K_ADD:  fs = 8;
      K_SUB:  begin fs = 9; c0 = 1; end
      K_AND:  fs = 0;
      K_ORR:  fs = 4;
      K_ADDI: begin fs = 8; imm = 1; end
      K_SUBI: begin fs = 9; c0 = 1; imm = 1; end
      K_ANDI: begin fs = 0; imm = 1; end
      K_ORRI: begin fs = 4; imm = 1; end
      default: alu = 0;
    endcase
    exp_pc = exp_pc + 64'd4;
    if (alu) begin
      w1 = pack(0, 0, 0, 1, 0, c0, fs, imm, 1, rm, rn, rd);
      if (imm) exp_const = 64'(ins[21:10]);
    end else if (k == K_LDUR || k == K_STUR) begin
      mem = 1;
      exp_const = 64'(sext(longint'(ins[20:12]), 9));
      w1 = pack(0, 0, 0, 1, 0, 0, 8, 1, 1, 31, rn, SCRATCH);
      if (k == K_STUR) w2 = pack(7, 1, 1, 0, 1, 0, 4, 0, 0, SCRATCH, rd, 0);
      else             w2 = pack(8, 1, 0, 0, 1, 0, 4, 0, 1, 31, SCRATCH, rd);
    end else if (k == K_CBZ) begin
      w1 = pack(0, 0, 0, 1, 0, 0, 4, 0, 0, 31, rd, 0);
      if (z) exp_pc = exp_pc - 64'd4 + 64'(sext(longint'(ins[23:5]), 19) * 4);
    end else if (k == K_B) begin
      exp_pc = exp_pc - 64'd4 + 64'(sext(longint'(ins[25:0]), 26) * 4);
    end else begin
      ill = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_cw", ControlWord, 0);
    chk("rst_const", constant, 0);
    chk("rst_pc", pc, PC_RESET_TB);
    chk("rst_retire", retire, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ready", instr_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    exp_pc = PC_RESET_TB;
    exp_const = 0;
  endtask

  // Entered and left at a negedge with the unit idle.
  task automatic run_instr(input logic [31:0] ins, input logic z, input bit noise,
                           output logic [31:0] o_w1, output logic [31:0] o_w2,
                           output logic [63:0] o_const);
    logic [31:0] w1, w2;
    bit mem, ill;
    kind_t k;
    k = classify(ins);
    model(ins, z, w1, w2, mem, ill);
    o_w2 = '0;
    instruction = ins;
    instr_valid = 1'b1;
    status = {3'($urandom), z};
    chk("ready_idle", instr_ready, 1);
    chk("cw_idle", ControlWord, 0);
    @(posedge clock);
    @(negedge clock);
    if (noise) instruction = $urandom;
    else instr_valid = 1'b0;
    chk("ready_busy", instr_ready, 0);
    chk("cw_first", ControlWord, w1);
    chk("constant", constant, exp_const);
    o_w1 = ControlWord;
    o_const = constant;
    if (mem) begin
      chk("retire_early", retire, 0);
      @(posedge clock);
      @(negedge clock);
      chk("ready_busy2", instr_ready, 0);
      chk("cw_mem_data", ControlWord, w2);
      o_w2 = ControlWord;
    end
    chk("retire", retire, 1);
    chk("illegal", illegal, ill);
    instr_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("pc", pc, exp_pc);
    chk("cw_after", ControlWord, 0);
    chk("retire_after", retire, 0);
    chk("ready_after", instr_ready, 1);
    $display("[TB] %s ins=%h z=%0d noise=%0d pc=%h cw=%h", k.name(), ins, z, noise, pc, o_w1);
  endtask

  function automatic logic [31:0] random_instr();
    logic [10:0] r_ops [4];
    logic [9:0]  i_ops [4];
    logic [31:0] w;
    r_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    i_ops = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};
    w = $urandom;
    case ($urandom_range(0, 6))
      0, 1: return {r_ops[$urandom_range(0, 3)], w[20:0]};
      2:    return {i_ops[$urandom_range(0, 3)], w[21:0]};
      3:    return {($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000,
                    w[20:12], 2'b00, w[9:0]};
      4:    return {8'b10110100, w[23:0]};
      5:    return {6'b000101, w[25:0]};
      default: begin
        for (int i = 0; i < 16; i++) begin
          if (classify(w) == K_ILL) return w;
          w = $urandom;
        end
        return 32'h0000_0000;
      end
    endcase
  endfunction

  logic [31:0] ow1, ow2, sub_ins;
  logic [63:0] oconst;

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; instruction = '0; instr_valid = 1'b0; status = '0;
    exp_pc = PC_RESET_TB; exp_const = 0;
    sub_ins = {11'b11001011000, 5'd0, 6'd0, 5'd31, 5'd1};

    do_reset();

    run_instr({10'b1011001000, 12'd24, 5'd31, 5'd0}, 1'b0, 1'b0, ow1, ow2, oconst);
    chk("orri_cw", ow1, 32'b00000_0_0_1_0_0_00100_1_1_00000_11111_00000);
    chk("orri_const", oconst, 64'd24);
    chk("orri_pc", pc, 64'd4);

    run_instr(sub_ins, 1'b0, 1'b0, ow1, ow2, oconst);
    chk("sub_cw", ow1, 32'b00000_0_0_1_0_1_01001_0_1_00000_11111_00001);
    chk("sub_const", oconst, 64'd24);

    run_instr({11'b11111000000, 9'd24, 2'b00, 5'd31, 5'd1}, 1'b0, 1'b0, ow1, ow2, oconst);
    chk("stur_data_cw", ow2, 32'b00111_1_1_0_1_0_00100_0_0_00111_00001_00000);

    run_instr({11'b11111000010, 9'h1F8, 2'b00, 5'd31, 5'd2}, 1'b0, 1'b1, ow1, ow2, oconst);
    chk("ldur_const", oconst, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_data_cw", ow2, 32'b01000_1_0_0_1_0_00100_0_1_11111_00111_00010);

    run_instr(32'hFFFF_FFFF, 1'b0, 1'b0, ow1, ow2, oconst);
    chk("illegal_pc", pc, 64'd20);

    do_reset();
    for (int i = 0; i < 4; i++) run_instr(sub_ins, 1'b1, 1'b0, ow1, ow2, oconst);
    run_instr({8'b10110100, 19'd4, 5'd3}, 1'b1, 1'b0, ow1, ow2, oconst);
    chk("cbz_taken_pc", pc, 64'h20);

    do_reset();
    for (int i = 0; i < 4; i++) run_instr(sub_ins, 1'b1, 1'b0, ow1, ow2, oconst);
    run_instr({8'b10110100, 19'd4, 5'd3}, 1'b0, 1'b0, ow1, ow2, oconst);
    chk("cbz_not_taken_pc", pc, 64'h14);

    do_reset();
    run_instr({6'b000101, 26'h3FF_FFFF}, 1'b0, 1'b0, ow1, ow2, oconst);
    chk("b_wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Abort an LDUR in its address phase.
    do_reset();
    instruction = {11'b11111000010, 9'd16, 2'b00, 5'd4, 5'd5};
    instr_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    chk("abort_addr_cw", ControlWord, pack(0, 0, 0, 1, 0, 0, 8, 1, 1, 31, 4, SCRATCH));
    #2 reset = 1'b1;
    #1;
    chk("abort_cw", ControlWord, 0);
    chk("abort_pc", pc, PC_RESET_TB);
    chk("abort_retire", retire, 0);
    @(posedge clock);
    #1;
    chk("abort_retire_hold", retire, 0);
    chk("abort_pc_hold", pc, PC_RESET_TB);
    @(negedge clock);
    reset = 1'b0;
    exp_pc = PC_RESET_TB;
    exp_const = 0;
    $display("[TB] reset during MEM_ADDR pc=%h cw=%h", pc, ControlWord);
    run_instr(sub_ins, 1'b0, 1'b0, ow1, ow2, oconst);

    for (int n = 0; n < 80; n++) begin
      run_instr(random_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ow1, ow2, oconst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
